// File: rtl/arb_mux_n.sv
// One-entry registered N:1 mux with a valid/ready handshake on both sides.
// The source is chosen by a fixed sel (MODE 0) or by round-robin arbitration (MODE 1).
module arb_mux_n #(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = 4,
    parameter int unsigned MODE = 0,
    localparam int unsigned SW  = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    input  logic           out_ready,
    output logic [SW-1:0]  out_chan
);

    logic          r_full;
    logic [W-1:0]  r_data;
    logic [SW-1:0] r_chan;
    logic [SW-1:0] r_ptr;

    logic          w_can_load;
    logic          w_found;
    logic [SW-1:0] w_idx;
    logic          w_hi_found;
    logic [SW-1:0] w_hi_idx;
    logic          w_lo_found;
    logic [SW-1:0] w_lo_idx;
    logic          w_grant;
    logic [W-1:0]  w_sel_data;
    logic [SW-1:0] w_ptr_next;

    assign w_can_load = !r_full || out_ready;

    always_comb begin
        w_found    = 1'b0;
        w_idx      = '0;
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        if (MODE == 0) begin
            // A sel value with no matching channel index never grants.
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    w_found = 1'b1;
                    w_idx   = SW'(i);
                end
            end
        end else begin
            // Descending scan: the last hit is the lowest index at/above ptr (hi)
            // or overall (lo, used when the search wraps).
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = SW'(i);
                    if (SW'(i) >= r_ptr) begin
                        w_hi_found = 1'b1;
                        w_hi_idx   = SW'(i);
                    end
                end
            end
            w_found = w_hi_found || w_lo_found;
            w_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
        end
    end

    assign w_grant    = w_found && w_can_load && !rst;
    assign w_ptr_next = (w_idx == SW'(N - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_idx == SW'(i)) begin
                w_sel_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (w_grant) begin
            in_ready = {{(N - 1){1'b0}}, 1'b1} << w_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_chan <= '0;
            r_ptr  <= '0;
        end else if (w_grant) begin
            r_full <= 1'b1;
            r_data <= w_sel_data;
            r_chan <= w_idx;
            r_ptr  <= w_ptr_next;
        end else if (out_ready) begin
            r_full <= 1'b0;
        end
    end

    assign out_valid = r_full;
    assign out_data  = r_data;
    assign out_chan  = r_chan;

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboard bench for arb_mux_n: one fixed-select and one round-robin instance,
// each checked against a small behavioural model.
module tb_arb_mux_n;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [3:0]  in_valid0, in_valid1, in_ready0, in_ready1;
    logic [31:0] in_data0, in_data1;
    logic [1:0]  sel0, sel1, out_chan0, out_chan1;
    logic        out_valid0, out_valid1, out_ready0, out_ready1;
    logic [7:0]  out_data0, out_data1;

    arb_mux_n #(.W(8), .N(4), .MODE(0)) u_fix (
        .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_data(in_data0),
        .in_ready(in_ready0), .sel(sel0), .out_valid(out_valid0),
        .out_data(out_data0), .out_ready(out_ready0), .out_chan(out_chan0)
    );

    arb_mux_n #(.W(8), .N(4), .MODE(1)) u_rr (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .sel(sel1), .out_valid(out_valid1),
        .out_data(out_data1), .out_ready(out_ready1), .out_chan(out_chan1)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic       m0_full = 1'b0;
    logic       m1_full = 1'b0;
    int         m1_ptr  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Held word must match the oldest scoreboard entry while the output is full.
    task automatic check_out(input string pfx, input logic full, input logic ov,
                             input logic [1:0] oc, input logic [7:0] od, input int depth,
                             input logic [9:0] front);
        check_eq({pfx, "_out_valid"}, 32'(ov), 32'(full));
        if (full) begin
            check_eq({pfx, "_sb_depth"}, 32'(depth), 32'd1);
            if (depth > 0) begin
                check_eq({pfx, "_out_chan"}, 32'(oc), 32'(front[9:8]));
                check_eq({pfx, "_out_data"}, 32'(od), 32'(front[7:0]));
            end
        end
    endtask

    task automatic step0(input logic [3:0] v, input logic [1:0] s, input logic ordy,
                         input logic [31:0] dat);
        int g;
        logic [3:0] er;
        logic [9:0] front;
        in_valid0  = v;
        sel0       = s;
        out_ready0 = ordy;
        in_data0   = dat;
        @(negedge clk);
        front = (q0.size() > 0) ? q0[0] : 10'd0;
        check_out("fix", m0_full, out_valid0, out_chan0, out_data0, q0.size(), front);
        g = -1;
        if ((!m0_full || ordy) && v[s]) g = int'(s);
        er = (g >= 0) ? 4'(1 << g) : 4'd0;
        check_eq("fix_in_ready", 32'(in_ready0), 32'(er));
        if (m0_full && ordy && q0.size() > 0) void'(q0.pop_front());
        if (g >= 0) begin
            q0.push_back({s, dat[g*8 +: 8]});
            m0_full = 1'b1;
        end else if (ordy) begin
            m0_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic [3:0] v, input logic ordy);
        int g;
        int idx;
        logic [3:0] er;
        logic [9:0] front;
        logic [31:0] dat;
        dat        = $urandom;
        in_valid1  = v;
        out_ready1 = ordy;
        in_data1   = dat;
        @(negedge clk);
        front = (q1.size() > 0) ? q1[0] : 10'd0;
        check_out("rr", m1_full, out_valid1, out_chan1, out_data1, q1.size(), front);
        g = -1;
        if (!m1_full || ordy) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m1_ptr + k) % 4;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        er = (g >= 0) ? 4'(1 << g) : 4'd0;
        check_eq("rr_in_ready", 32'(in_ready1), 32'(er));
        if (m1_full && ordy && q1.size() > 0) void'(q1.pop_front());
        if (g >= 0) begin
            q1.push_back({2'(g), dat[g*8 +: 8]});
            m1_ptr  = (g + 1) % 4;
            m1_full = 1'b1;
        end else if (ordy) begin
            m1_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        in_valid0 = 4'hF; in_valid1 = 4'hF;
        in_data0 = 32'h1234_5678; in_data1 = 32'h9ABC_DEF0;
        sel0 = 2'd0; sel1 = 2'd0;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_eq("rst_in_ready0", 32'(in_ready0), 32'd0);
            check_eq("rst_in_ready1", 32'(in_ready1), 32'd0);
            check_eq("rst_out_valid0", 32'(out_valid0), 32'd0);
            check_eq("rst_out_valid1", 32'(out_valid1), 32'd0);
            check_eq("rst_outs0", {22'd0, out_chan0, out_data0}, 32'd0);
            check_eq("rst_outs1", {22'd0, out_chan1, out_data1}, 32'd0);
            @(posedge clk);
            #1;
        end
        rst0 = 1'b0; rst1 = 1'b0;
        in_valid0 = 4'h0; in_valid1 = 4'h0;

        // Fixed select: basic grant, blocked sel, backpressure, drain+load.
        step0(4'b0100, 2'd2, 1'b1, 32'h00A5_0000);
        step0(4'b0000, 2'd2, 1'b1, 32'h0);
        step0(4'b1101, 2'd1, 1'b1, $urandom);
        step0(4'b1101, 2'd3, 1'b1, $urandom);
        step0(4'b0001, 2'd0, 1'b0, $urandom);
        step0(4'b0001, 2'd0, 1'b0, $urandom);
        step0(4'b1111, 2'd1, 1'b1, $urandom);
        step0(4'b1111, 2'd0, 1'b1, $urandom);
        for (int c = 0; c < 6; c++) step0(4'($urandom), 2'($urandom), 1'($urandom), $urandom);
        step0(4'b0000, 2'd0, 1'b1, 32'h0);

        // Round robin: full rotation with sustained throughput.
        for (int c = 0; c < 5; c++) step1(4'b1111, 1'b1);
        step1(4'b0000, 1'b1);
        // Hold a ch1 word under backpressure, then release.
        step1(4'b0010, 1'b0);
        for (int c = 0; c < 3; c++) step1(4'b1111, 1'b0);
        step1(4'b1111, 1'b1);
        step1(4'b0000, 1'b1);
        // Pointer at 3 with only ch0 valid wraps; then ptr=1 picks ch3 over ch0.
        step1(4'b0001, 1'b1);
        step1(4'b1001, 1'b1);
        step1(4'b0000, 1'b1);
        // Mid-transfer reset discards the word and restarts the pointer.
        step1(4'b0100, 1'b0);
        rst1 = 1'b1;
        out_ready1 = 1'b0;
        in_valid1 = 4'b1111;
        @(negedge clk);
        check_eq("midrst_in_ready", 32'(in_ready1), 32'd0);
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        q1.delete();
        m1_full = 1'b0;
        m1_ptr  = 0;
        step1(4'b1010, 1'b1);
        step1(4'b0000, 1'b1);
        for (int c = 0; c < 10; c++) step1(4'($urandom), 1'($urandom));
        step1(4'b0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
